// File: rtl/bus_err_axi_tap.sv
// bus_err_axi_tap
// Passive AXI4 snoop feeding the bus error unit. It never drives ready; it
// only watches handshakes and re-emits them, registered, as error-unit events.
//
// Request side (latency 1):
//   port 0 <- AR handshake, req_hs_valid_o[0] = 2'b01
//   port 1 <- AW handshake, req_hs_valid_o[1] = 2'b10
//   req_addr_o / req_meta_o hold the last handshaken value of each port.
// Response side (latency 1, at most one event per cycle):
//   R always wins and is never buffered. A B response that collides with R,
//   or that arrives while older B responses are waiting, goes into a small
//   FIFO. Buffered B responses drain whenever no R is present.
//   b_pending_o  : FIFO occupancy after this cycle's push/pop
//   overflow_o   : sticky, set when a B response had to be dropped
//
// Ports: clk_i, rst_ni (async, active low), AXI AR/AW/R/B observation
// inputs, request event outputs (2 ports), response event outputs.

// Per-port request capture: one-cycle pulse plus held address/metadata.
module bus_err_axi_tap_req_port #(
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned MetaDataWidth = 1,
  parameter logic [1:0]  ChanOh        = 2'b01
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     hs_i,
  input  logic [AddrWidth-1:0]     addr_i,
  input  logic [MetaDataWidth-1:0] meta_i,
  output logic [1:0]               hs_valid_o,
  output logic [AddrWidth-1:0]     addr_o,
  output logic [MetaDataWidth-1:0] meta_o
);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hs_valid_o <= '0;
      addr_o     <= '0;
      meta_o     <= '0;
    end else begin
      hs_valid_o <= hs_i ? ChanOh : 2'b00;
      if (hs_i) begin
        addr_o <= addr_i;
        meta_o <= meta_i;
      end
    end
  end
endmodule

module bus_err_axi_tap #(
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned MetaDataWidth = 1,
  parameter int unsigned ErrBits       = 3,
  parameter int unsigned BufDepth      = 4,
  localparam int unsigned CntW         = $clog2(BufDepth + 1)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                ar_valid_i,
  input  logic                                ar_ready_i,
  input  logic [AddrWidth-1:0]                ar_addr_i,
  input  logic [MetaDataWidth-1:0]            ar_meta_i,
  input  logic                                aw_valid_i,
  input  logic                                aw_ready_i,
  input  logic [AddrWidth-1:0]                aw_addr_i,
  input  logic [MetaDataWidth-1:0]            aw_meta_i,
  input  logic                                r_valid_i,
  input  logic                                r_ready_i,
  input  logic                                r_last_i,
  input  logic [1:0]                          r_resp_i,
  input  logic                                b_valid_i,
  input  logic                                b_ready_i,
  input  logic [1:0]                          b_resp_i,
  output logic [1:0][1:0]                     req_hs_valid_o,
  output logic [1:0][AddrWidth-1:0]           req_addr_o,
  output logic [1:0][MetaDataWidth-1:0]       req_meta_o,
  output logic [1:0]                          rsp_hs_valid_o,
  output logic [1:0]                          rsp_burst_last_o,
  output logic [ErrBits-1:0]                  rsp_err_o,
  output logic [CntW-1:0]                     b_pending_o,
  output logic                                overflow_o
);
  localparam int unsigned PtrW = (BufDepth > 1) ? $clog2(BufDepth) : 1;

  typedef struct packed {
    logic [1:0]         vld;
    logic [1:0]         last;
    logic [ErrBits-1:0] err;
  } rsp_t;

  // ---------------- request path ----------------
  logic [1:0]                     req_hs;
  logic [1:0][AddrWidth-1:0]      req_addr_in;
  logic [1:0][MetaDataWidth-1:0]  req_meta_in;

  assign req_hs      = {aw_valid_i & aw_ready_i, ar_valid_i & ar_ready_i};
  assign req_addr_in = {aw_addr_i, ar_addr_i};
  assign req_meta_in = {aw_meta_i, ar_meta_i};

  for (genvar g = 0; g < 2; g++) begin : g_req
    bus_err_axi_tap_req_port #(
      .AddrWidth     (AddrWidth),
      .MetaDataWidth (MetaDataWidth),
      .ChanOh        (2'(1 << g))
    ) u_port (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .hs_i       (req_hs[g]),
      .addr_i     (req_addr_in[g]),
      .meta_i     (req_meta_in[g]),
      .hs_valid_o (req_hs_valid_o[g]),
      .addr_o     (req_addr_o[g]),
      .meta_o     (req_meta_o[g])
    );
  end

  // ---------------- response path ----------------
  logic r_hs, b_hs;
  assign r_hs = r_valid_i & r_ready_i;
  assign b_hs = b_valid_i & b_ready_i;

  logic [1:0]      b_mem [BufDepth];
  logic [PtrW-1:0] rd_ptr, wr_ptr;
  logic [CntW-1:0] cnt;
  logic            ovf_q;

  logic empty, full, pop, push_req, push, drop;

  assign empty    = (cnt == '0);
  assign full     = (cnt == CntW'(BufDepth));
  // Buffer head drains only in cycles without R.
  assign pop      = ~r_hs & ~empty;
  // B must queue if R owns the output this cycle or older B's are waiting;
  // otherwise it bypasses the buffer.
  assign push_req = b_hs & (r_hs | ~empty);
  // A full buffer still accepts when its head leaves in the same cycle.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(BufDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + CntW'(1);
        2'b01:   cnt <= cnt - CntW'(1);
        default: cnt <= cnt;
      endcase
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Storage carries no reset; the pointers/count define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) b_mem[wr_ptr] <= b_resp_i;
  end

  rsp_t rsp_d, rsp_q;

  always_comb begin
    rsp_d = '0;
    if (r_hs) begin
      rsp_d.vld  = 2'b01;
      rsp_d.last = {1'b0, r_last_i};
      rsp_d.err  = ErrBits'(r_resp_i);
    end else if (!empty) begin
      rsp_d.vld  = 2'b10;
      rsp_d.last = 2'b10;
      rsp_d.err  = ErrBits'(b_mem[rd_ptr]);
    end else if (b_hs) begin
      rsp_d.vld  = 2'b10;
      rsp_d.last = 2'b10;
      rsp_d.err  = ErrBits'(b_resp_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rsp_q <= '0;
    else         rsp_q <= rsp_d;
  end

  assign rsp_hs_valid_o   = rsp_q.vld;
  assign rsp_burst_last_o = rsp_q.last;
  assign rsp_err_o        = rsp_q.err;
  assign b_pending_o      = cnt;
  assign overflow_o       = ovf_q;

endmodule

// File: tb/tb_bus_err_axi_tap.sv
module tb_bus_err_axi_tap;
  localparam int AW = 48;
  localparam int MW = 1;
  localparam int EB = 3;
  localparam int BD = 4;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic ar_valid, ar_ready, aw_valid, aw_ready;
  logic [AW-1:0] ar_addr, aw_addr;
  logic [MW-1:0] ar_meta, aw_meta;
  logic r_valid, r_ready, r_last, b_valid, b_ready;
  logic [1:0] r_resp, b_resp;

  logic [1:0][1:0]    req_hs_valid_o;
  logic [1:0][AW-1:0] req_addr_o;
  logic [1:0][MW-1:0] req_meta_o;
  logic [1:0]         rsp_hs_valid_o, rsp_burst_last_o;
  logic [EB-1:0]      rsp_err_o;
  logic [2:0]         b_pending_o;
  logic               overflow_o;

  int n_tests = 0;
  int n_fail  = 0;

  wire [6:0] rsp_v = {rsp_hs_valid_o, rsp_burst_last_o, rsp_err_o};

  always #5 clk = ~clk;

  bus_err_axi_tap #(.AddrWidth(AW), .MetaDataWidth(MW), .ErrBits(EB), .BufDepth(BD)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .ar_valid_i(ar_valid), .ar_ready_i(ar_ready), .ar_addr_i(ar_addr), .ar_meta_i(ar_meta),
    .aw_valid_i(aw_valid), .aw_ready_i(aw_ready), .aw_addr_i(aw_addr), .aw_meta_i(aw_meta),
    .r_valid_i(r_valid), .r_ready_i(r_ready), .r_last_i(r_last), .r_resp_i(r_resp),
    .b_valid_i(b_valid), .b_ready_i(b_ready), .b_resp_i(b_resp),
    .req_hs_valid_o(req_hs_valid_o), .req_addr_o(req_addr_o), .req_meta_o(req_meta_o),
    .rsp_hs_valid_o(rsp_hs_valid_o), .rsp_burst_last_o(rsp_burst_last_o), .rsp_err_o(rsp_err_o),
    .b_pending_o(b_pending_o), .overflow_o(overflow_o)
  );

  task automatic idle();
    ar_valid = 0; ar_ready = 0; aw_valid = 0; aw_ready = 0;
    r_valid = 0; r_ready = 0; r_last = 0; r_resp = 0;
    b_valid = 0; b_ready = 0; b_resp = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_r(input logic last, input logic [1:0] resp);
    r_valid = 1; r_ready = 1; r_last = last; r_resp = resp;
  endtask

  task automatic set_b(input logic [1:0] resp);
    b_valid = 1; b_ready = 1; b_resp = resp;
  endtask

  task automatic test_reset();
    idle(); ar_addr = '0; aw_addr = '0; ar_meta = '0; aw_meta = '0;
    rst_ni = 0;
    #12;
    n_tests++; if ({req_hs_valid_o, req_addr_o, req_meta_o} !== '0) begin n_fail++; $display("FAIL reset_req got %h exp 0", {req_hs_valid_o, req_addr_o, req_meta_o}); end
    n_tests++; if ({rsp_v, b_pending_o, overflow_o} !== '0) begin n_fail++; $display("FAIL reset_rsp got %h exp 0", {rsp_v, b_pending_o, overflow_o}); end
    @(negedge clk); rst_ni = 1;
    tick();
  endtask

  task automatic test_single_ar_r();
    idle(); ar_valid = 1; ar_ready = 1; ar_addr = 48'h1000; ar_meta = 1'b1;
    tick(); idle();
    n_tests++; if (req_hs_valid_o !== {2'b00, 2'b01}) begin n_fail++; $display("FAIL ar_hs got %b exp 0001", req_hs_valid_o); end
    n_tests++; if (req_addr_o[0] !== 48'h1000 || req_meta_o[0] !== 1'b1) begin n_fail++; $display("FAIL ar_addr got %h/%b exp 1000/1", req_addr_o[0], req_meta_o[0]); end
    ar_addr = 48'hdead; // valid low: must not be captured
    tick();
    n_tests++; if (req_hs_valid_o !== '0 || req_addr_o[0] !== 48'h1000) begin n_fail++; $display("FAIL ar_pulse got %b/%h exp 0/1000", req_hs_valid_o, req_addr_o[0]); end
    tick();
    set_r(1'b1, 2'b10);
    tick(); idle();
    n_tests++; if (rsp_v !== 7'b01_01_010) begin n_fail++; $display("FAIL r_event got %b exp 0101010", rsp_v); end
    tick();
    n_tests++; if (rsp_v !== 7'b0) begin n_fail++; $display("FAIL r_idle got %b exp 0", rsp_v); end
  endtask

  task automatic test_ar_aw_same();
    idle();
    ar_valid = 1; ar_ready = 1; ar_addr = 48'h1234_5678_9abc; ar_meta = 1'b0;
    aw_valid = 1; aw_ready = 1; aw_addr = 48'hfedc_ba98_7654; aw_meta = 1'b1;
    tick(); idle();
    n_tests++; if (req_hs_valid_o !== {2'b10, 2'b01}) begin n_fail++; $display("FAIL araw_hs got %b exp 1001", req_hs_valid_o); end
    n_tests++; if (req_addr_o !== {48'hfedc_ba98_7654, 48'h1234_5678_9abc} || req_meta_o !== 2'b10) begin n_fail++; $display("FAIL araw_addr got %h/%b", req_addr_o, req_meta_o); end
    aw_valid = 1; aw_ready = 0; aw_addr = 48'h1; ar_valid = 0; ar_ready = 1; ar_addr = 48'h2;
    tick(); idle();
    n_tests++; if (req_hs_valid_o !== '0 || req_addr_o !== {48'hfedc_ba98_7654, 48'h1234_5678_9abc}) begin n_fail++; $display("FAIL nohs_hold got %b/%h", req_hs_valid_o, req_addr_o); end
  endtask

  task automatic test_rb_collision();
    idle(); set_r(1'b0, 2'b00); set_b(2'b11);
    tick(); idle();
    n_tests++; if (rsp_v !== 7'b01_00_000 || b_pending_o !== 3'd1) begin n_fail++; $display("FAIL coll_r got %b/%0d exp 0100000/1", rsp_v, b_pending_o); end
    tick();
    n_tests++; if (rsp_v !== 7'b10_10_011 || b_pending_o !== 3'd0) begin n_fail++; $display("FAIL coll_b got %b/%0d exp 1010011/0", rsp_v, b_pending_o); end
    tick();
    n_tests++; if (rsp_v !== 7'b0) begin n_fail++; $display("FAIL coll_idle got %b exp 0", rsp_v); end
  endtask

  task automatic test_burst();
    logic [1:0] rr [4];
    logic [2:0] pend [4];
    rr[0] = 2'd0; rr[1] = 2'd1; rr[2] = 2'd0; rr[3] = 2'd3;
    pend[0] = 3'd1; pend[1] = 3'd1; pend[2] = 3'd2; pend[3] = 3'd2;
    for (int i = 0; i < 4; i++) begin
      idle(); set_r(i == 3, rr[i]);
      if (i == 0) set_b(2'b01);
      if (i == 2) set_b(2'b10);
      tick();
      n_tests++; if (rsp_v !== {2'b01, 1'b0, i == 3, 1'b0, rr[i]} || b_pending_o !== pend[i]) begin n_fail++; $display("FAIL burst_beat%0d got %b/%0d exp %b/%0d", i, rsp_v, b_pending_o, {2'b01, 1'b0, i == 3, 1'b0, rr[i]}, pend[i]); end
    end
    idle(); tick();
    n_tests++; if (rsp_v !== 7'b10_10_001 || b_pending_o !== 3'd1) begin n_fail++; $display("FAIL burst_b0 got %b/%0d exp 1010001/1", rsp_v, b_pending_o); end
    tick();
    n_tests++; if (rsp_v !== 7'b10_10_010 || b_pending_o !== 3'd0 || overflow_o !== 1'b0) begin n_fail++; $display("FAIL burst_b1 got %b/%0d/%b exp 1010010/0/0", rsp_v, b_pending_o, overflow_o); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) begin
      idle(); set_r(i == 7, 2'b00); set_b(2'(i));
      tick();
      n_tests++; if (b_pending_o !== 3'((i < 4) ? i + 1 : 4) || overflow_o !== (i >= 4)) begin n_fail++; $display("FAIL ovf_fill%0d got %0d/%b exp %0d/%b", i, b_pending_o, overflow_o, (i < 4) ? i + 1 : 4, i >= 4); end
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++; if (rsp_v !== {4'b1010, 1'b0, 2'(i)} || b_pending_o !== 3'(3 - i) || overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_drain%0d got %b/%0d/%b exp %b/%0d/1", i, rsp_v, b_pending_o, overflow_o, {4'b1010, 1'b0, 2'(i)}, 3 - i); end
    end
    tick();
    n_tests++; if (rsp_v !== 7'b0 || overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b/%b exp 0/1", rsp_v, overflow_o); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      idle(); set_r(1'b0, 2'b01); set_b(2'b10);
      tick();
    end
    n_tests++; if (b_pending_o !== 3'd3 || overflow_o !== 1'b1) begin n_fail++; $display("FAIL arst_pre got %0d/%b exp 3/1", b_pending_o, overflow_o); end
    #3; rst_ni = 0; idle();
    #1;
    n_tests++; if ({rsp_v, b_pending_o, overflow_o} !== '0) begin n_fail++; $display("FAIL arst_rsp got %h exp 0", {rsp_v, b_pending_o, overflow_o}); end
    n_tests++; if ({req_hs_valid_o, req_addr_o, req_meta_o} !== '0) begin n_fail++; $display("FAIL arst_req got %h exp 0", {req_hs_valid_o, req_addr_o, req_meta_o}); end
    #2; rst_ni = 1;
    set_b(2'b01);
    tick(); idle();
    n_tests++; if (rsp_v !== 7'b10_10_001 || b_pending_o !== 3'd0) begin n_fail++; $display("FAIL arst_bypass got %b/%0d exp 1010001/0", rsp_v, b_pending_o); end
    tick();
    n_tests++; if (rsp_v !== 7'b0) begin n_fail++; $display("FAIL arst_idle got %b exp 0", rsp_v); end
  endtask

  // Reference: queue of waiting B codes; R owns the output, otherwise oldest
  // waiting B, otherwise a fresh B. Starts from the post-reset state.
  task automatic test_random();
    logic [1:0] q [$];
    logic ovf = 1'b0;
    logic [1:0][1:0]    e_hs;
    logic [1:0][AW-1:0] e_addr = '0;
    logic [1:0][MW-1:0] e_meta = '0;
    logic [6:0] e_rsp;
    logic rh, bh;
    int rp;
    for (int c = 0; c < 400; c++) begin
      rp = (c < 120) ? 90 : (c < 260) ? 45 : 10;
      ar_valid = 1'($urandom_range(1)); ar_ready = 1'($urandom_range(1));
      aw_valid = 1'($urandom_range(1)); aw_ready = 1'($urandom_range(1));
      ar_addr = AW'({$urandom(), $urandom()}); aw_addr = AW'({$urandom(), $urandom()});
      ar_meta = MW'($urandom()); aw_meta = MW'($urandom());
      r_valid = ($urandom_range(99) < rp); r_ready = ($urandom_range(99) < 80);
      r_last = 1'($urandom_range(1)); r_resp = 2'($urandom());
      b_valid = ($urandom_range(99) < 60); b_ready = ($urandom_range(99) < 80);
      b_resp = 2'($urandom());
      e_hs = '0;
      if (ar_valid && ar_ready) begin e_hs[0] = 2'b01; e_addr[0] = ar_addr; e_meta[0] = ar_meta; end
      if (aw_valid && aw_ready) begin e_hs[1] = 2'b10; e_addr[1] = aw_addr; e_meta[1] = aw_meta; end
      rh = r_valid & r_ready; bh = b_valid & b_ready;
      e_rsp = '0;
      if (rh) begin
        e_rsp = {2'b01, 1'b0, r_last, 1'b0, r_resp};
        if (bh) begin
          if (q.size() < BD) q.push_back(b_resp);
          else ovf = 1'b1;
        end
      end else if (q.size() > 0) begin
        e_rsp = {4'b1010, 1'b0, q.pop_front()};
        if (bh) q.push_back(b_resp);
      end else if (bh) begin
        e_rsp = {4'b1010, 1'b0, b_resp};
      end
      tick();
      n_tests++; if (req_hs_valid_o !== e_hs || req_addr_o !== e_addr || req_meta_o !== e_meta) begin n_fail++; $display("FAIL rnd_req c%0d got %b/%h exp %b/%h", c, req_hs_valid_o, req_addr_o, e_hs, e_addr); end
      n_tests++; if (rsp_v !== e_rsp) begin n_fail++; $display("FAIL rnd_rsp c%0d got %b exp %b", c, rsp_v, e_rsp); end
      n_tests++; if (b_pending_o !== 3'(q.size()) || overflow_o !== ovf) begin n_fail++; $display("FAIL rnd_buf c%0d got %0d/%b exp %0d/%b", c, b_pending_o, overflow_o, q.size(), ovf); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single_ar_r();
    test_ar_aw_same();
    test_rb_collision();
    test_burst();
    test_overflow();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
